shared_mem_arbiter: RTL and testbench
=====================================

// Module: shared_mem_arbiter
// PURPOSE
// - Arbitrates the CPU's single unified memory between two requesters: instruction fetch (IF) and data access (MEM stage, load/store).
// - Sits between the pipeline and the single memory and replaces the ad-hoc fetch-stall/address mux.
// - Uses a req/ack handshake on both sides, so the memory may take a variable number of cycles.
// - Data requests win by default, because the older instruction must complete first.
// PARAMETERS
// - ADDR_W        32  address width of all address ports
// - DATA_W        32  data width of all data ports
// - MAX_D_STREAK  4   consecutive data grants allowed while fetch waits (FETCH_STARVE_GUARD_EN only); legal range 1..15
// PORTS
// - clk          in   1       clock; all state updates on rising edge
// - rst          in   1       reset, asynchronous, active-low
// - halt         in   1       ebreak halt; blocks new grants
// - if_req       in   1       fetch request; held until if_ack
// - if_addr      in   ADDR_W  fetch address (PC)
// - if_ack       out  1       one-cycle pulse; if_rdata valid
// - if_rdata     out  DATA_W  fetched instruction
// - d_req        in   1       data request; held until d_ack
// - d_we         in   1       1 = store, 0 = load
// - d_func3      in   3       access size/sign (RV32I funct3)
// - d_addr       in   ADDR_W  data address (ALU result)
// - d_wdata      in   DATA_W  store data
// - d_ack        out  1       one-cycle pulse; d_rdata valid
// - d_rdata      out  DATA_W  load data
// - mem_req      out  1       memory transaction request
// - mem_we       out  1       memory write enable
// - mem_func3    out  3       memory access size
// - mem_addr     out  ADDR_W  memory address
// - mem_wdata    out  DATA_W  memory write data
// - mem_ack      in   1       memory completion; mem_rdata valid this cycle
// - mem_rdata    in   DATA_W  memory read data
// - busy         out  1       1 while a transaction is outstanding
// BEHAVIOUR
// - All outputs are registered.
// - Reset (rst=0): state IDLE; every output is 0, including the rdata outputs; streak counter 0. Reset takes effect immediately, not on a clock edge.
// - FSM states:
//   - IDLE:
//     - If halt=1: stay in IDLE, issue nothing.
//     - Else if d_req: latch d_we/d_func3/d_addr/d_wdata onto mem_* and go to D_WAIT.
//     - Else if if_req: latch mem_we=0, mem_func3=3'b010, mem_addr=if_addr, mem_wdata=0 and go to IF_WAIT.
//     - Both transitions set mem_req=1 and busy=1.
//   - D_WAIT / IF_WAIT:
//     - mem_req and all mem_* fields are held stable.
//     - On mem_ack: capture mem_rdata into d_rdata/if_rdata, drop mem_req, pulse the matching ack next cycle, go to RESP.
//   - RESP:
//     - Ack is high for exactly this cycle; the matching rdata is valid from this cycle on.
//     - busy=0 on entry to RESP. Requests are ignored this cycle, so there is no double issue. Next state is IDLE.
// - Latency:
//   - A req sampled at edge N gives mem_req=1 in cycle N+1.
//   - mem_ack in cycle M gives the ack in cycle M+1.
//   - Minimum round trip is 2 cycles; the next grant is sampled 3 cycles after the request.
// - Boundary conditions:
//   - Simultaneous if_req and d_req: data is granted, fetch waits in IDLE.
//   - Requester drops req mid-transaction: the transaction still completes and the ack still pulses (requester ignores it). No abort.
//   - halt asserted in a WAIT state: the in-flight transaction completes normally; only new grants are blocked.
//   - mem_ack in IDLE or RESP: ignored.
//   - Stores: d_rdata still captures mem_rdata; the value is don't-care.
//   - if_rdata and d_rdata hold their value until the next capture.
//   - Reset mid-transaction: the pending request is lost and no ack is issued.
// CONFIGURATION
// - FETCH_STARVE_GUARD_EN defined:
//   - A 4-bit streak counter increments on each data grant made while if_req=1.
//   - The counter clears on any fetch grant, or on a data grant made while if_req=0.
//   - When streak == MAX_D_STREAK and if_req=1, the next IDLE grant goes to fetch even if d_req=1.
// - FETCH_STARVE_GUARD_EN undefined:
//   - Strict data priority; no counter is instantiated.
// TESTING
// - Fetch only: if_req=1, if_addr=0x10, mem_ack 1 cycle after mem_req with mem_rdata=0x00500093
//   -> mem_we=0, mem_func3=010, mem_addr=0x10
//   -> if_ack is a single pulse, if_rdata=0x00500093, busy falls.
// - Contention: if_req=1 and d_req=1 (store) in the same cycle, with d_addr=0x40, d_wdata=0xDEADBEEF, d_func3=010
//   -> data is issued first with mem_we=1, mem_addr=0x40
//   -> d_ack precedes if_ack, then the fetch is issued.
// - Slow memory: mem_ack delayed 3 cycles
//   -> mem_req/mem_addr/mem_wdata stay stable for all 3 cycles
//   -> exactly one ack, 1 cycle after mem_ack.
// - Halt: halt=1 with if_req=1 -> mem_req stays 0 for 10 cycles.
//   Halt raised during D_WAIT -> the transaction completes and d_ack pulses, then no new grant is made.
// - Reset mid-op: rst=0 during D_WAIT -> all outputs 0 without a clock edge.
//   After release, if_req at 0x20 -> served normally with no spurious d_ack.
// - Guard, MAX_D_STREAK=4: d_req=1 and if_req=1 held for 30 cycles, requesters re-asserting after each ack
//   -> with macro: grant order D,D,D,D,F,D,...
//   -> without macro: fetch is never granted.

Source files
------------

// File: rtl/shared_mem_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the arbiter and the unified memory.
interface shared_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [2:0]        d_func3;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_func3, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_func3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Unified-memory arbiter: data access beats instruction fetch; all outputs registered.
// Define FETCH_STARVE_GUARD_EN to force a fetch grant after MAX_D_STREAK back-to-back data grants.
//
// state   | meaning
// IDLE    | no transaction; grant the next request unless halted
// D_WAIT  | data transaction on the memory bus, waiting for mem_ack
// IF_WAIT | fetch transaction on the memory bus, waiting for mem_ack
// RESP    | ack pulse to the winner; requests ignored this cycle
module shared_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_halt,
  shared_mem_arbiter_if.slave bus,
  output logic                o_busy
);

  typedef enum logic [1:0] {IDLE, D_WAIT, IF_WAIT, RESP} state_t;

  state_t            r_state,     w_state_nxt;
  logic              r_mem_req,   w_mem_req_nxt;
  logic              r_mem_we,    w_mem_we_nxt;
  logic [2:0]        r_mem_func3, w_mem_func3_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_if_ack,    w_if_ack_nxt;
  logic              r_d_ack,     w_d_ack_nxt;
  logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata,   w_d_rdata_nxt;
  logic              r_busy,      w_busy_nxt;
  logic              w_grant_d;

`ifdef FETCH_STARVE_GUARD_EN
  logic [3:0] r_streak, w_streak_nxt;
  logic       w_fetch_turn;

  // Fetch has waited through MAX_D_STREAK data grants: it takes the next slot.
  assign w_fetch_turn = bus.if_req && (r_streak == 4'(MAX_D_STREAK));
  assign w_grant_d    = bus.d_req && !w_fetch_turn;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_streak <= 4'd0;
    else          r_streak <= w_streak_nxt;
  end
`else
  logic [3:0] w_unused_max_streak;

  assign w_unused_max_streak = 4'(MAX_D_STREAK);
  assign w_grant_d           = bus.d_req;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_func3_nxt = r_mem_func3;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_ack_nxt    = 1'b0;
    w_d_ack_nxt     = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_busy_nxt      = r_busy;
`ifdef FETCH_STARVE_GUARD_EN
    w_streak_nxt    = r_streak;
`endif
    case (r_state)
      IDLE: begin
        if (!i_halt) begin
          if (w_grant_d) begin
            w_state_nxt     = D_WAIT;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = bus.d_we;
            w_mem_func3_nxt = bus.d_func3;
            w_mem_addr_nxt  = bus.d_addr;
            w_mem_wdata_nxt = bus.d_wdata;
            w_busy_nxt      = 1'b1;
`ifdef FETCH_STARVE_GUARD_EN
            w_streak_nxt    = bus.if_req ? r_streak + 4'd1 : 4'd0;
`endif
          end else if (bus.if_req) begin
            w_state_nxt     = IF_WAIT;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = 1'b0;
            w_mem_func3_nxt = 3'b010;
            w_mem_addr_nxt  = bus.if_addr;
            w_mem_wdata_nxt = '0;
            w_busy_nxt      = 1'b1;
`ifdef FETCH_STARVE_GUARD_EN
            w_streak_nxt    = 4'd0;
`endif
          end
        end
      end
      D_WAIT: begin
        if (bus.mem_ack) begin
          w_state_nxt   = RESP;
          w_mem_req_nxt = 1'b0;
          w_d_ack_nxt   = 1'b1;
          w_d_rdata_nxt = bus.mem_rdata;
          w_busy_nxt    = 1'b0;
        end
      end
      IF_WAIT: begin
        if (bus.mem_ack) begin
          w_state_nxt    = RESP;
          w_mem_req_nxt  = 1'b0;
          w_if_ack_nxt   = 1'b1;
          w_if_rdata_nxt = bus.mem_rdata;
          w_busy_nxt     = 1'b0;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_func3 <= 3'b000;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_func3 <= w_mem_func3_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_ack    <= w_if_ack_nxt;
      r_d_ack     <= w_d_ack_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_func3 = r_mem_func3;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_rdata   = r_d_rdata;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: each step drives the requesters/memory and
// checks registered outputs 1 ns after the rising edge against hand-computed values.
module tb_shared_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic halt;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   guard_on;
  logic exp_fetch;

  shared_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_halt  (halt),
    .bus     (bus),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_req"},   64'(bus.mem_req),   64'd0);
    chk({tag, ".mem_we"},    64'(bus.mem_we),    64'd0);
    chk({tag, ".mem_func3"}, 64'(bus.mem_func3), 64'd0);
    chk({tag, ".mem_addr"},  64'(bus.mem_addr),  64'd0);
    chk({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    chk({tag, ".if_ack"},    64'(bus.if_ack),    64'd0);
    chk({tag, ".d_ack"},     64'(bus.d_ack),     64'd0);
    chk({tag, ".if_rdata"},  64'(bus.if_rdata),  64'd0);
    chk({tag, ".d_rdata"},   64'(bus.d_rdata),   64'd0);
    chk({tag, ".busy"},      64'(busy),          64'd0);
  endtask

  initial begin
`ifdef FETCH_STARVE_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif
    halt          = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_func3   = 3'b000;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    rst_n = 1'b0;
    #3;
    chk_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // Fetch only
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    tick();
    chk("f.mem_req",   64'(bus.mem_req),   64'd1);
    chk("f.mem_we",    64'(bus.mem_we),    64'd0);
    chk("f.mem_func3", 64'(bus.mem_func3), 64'd2);
    chk("f.mem_addr",  64'(bus.mem_addr),  64'h10);
    chk("f.mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("f.busy",      64'(busy),          64'd1);
    tick();
    chk("f.wait_req",  64'(bus.mem_req),   64'd1);
    chk("f.wait_ack",  64'(bus.if_ack),    64'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    tick();
    chk("f.if_ack",    64'(bus.if_ack),    64'd1);
    chk("f.if_rdata",  64'(bus.if_rdata),  64'h0050_0093);
    chk("f.busy_fall", 64'(busy),          64'd0);
    chk("f.req_drop",  64'(bus.mem_req),   64'd0);
    chk("f.no_d_ack",  64'(bus.d_ack),     64'd0);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    tick();
    chk("f.ack_pulse", 64'(bus.if_ack),    64'd0);
    chk("f.hold",      64'(bus.if_rdata),  64'h0050_0093);
    bus.mem_ack = 1'b1;
    tick();
    chk("stray.req",   64'(bus.mem_req),   64'd0);
    chk("stray.ifack", 64'(bus.if_ack),    64'd0);
    chk("stray.dack",  64'(bus.d_ack),     64'd0);
    bus.mem_ack = 1'b0;

    // Contention: store wins over fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h14;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_func3 = 3'b010;
    bus.d_addr  = 32'h40;
    bus.d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("c.mem_req",   64'(bus.mem_req),   64'd1);
    chk("c.mem_we",    64'(bus.mem_we),    64'd1);
    chk("c.mem_addr",  64'(bus.mem_addr),  64'h40);
    chk("c.mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
    chk("c.mem_func3", 64'(bus.mem_func3), 64'd2);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    tick();
    chk("c.d_ack",     64'(bus.d_ack),     64'd1);
    chk("c.if_ack0",   64'(bus.if_ack),    64'd0);
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    tick();
    chk("c.idle_req",  64'(bus.mem_req),   64'd0);
    chk("c.d_ack0",    64'(bus.d_ack),     64'd0);
    tick();
    chk("c.f_req",     64'(bus.mem_req),   64'd1);
    chk("c.f_addr",    64'(bus.mem_addr),  64'h14);
    chk("c.f_we",      64'(bus.mem_we),    64'd0);
    chk("c.f_wdata",   64'(bus.mem_wdata), 64'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hAABB_CCDD;
    tick();
    chk("c.if_ack",    64'(bus.if_ack),    64'd1);
    chk("c.if_rdata",  64'(bus.if_rdata),  64'hAABB_CCDD);
    chk("c.d_hold",    64'(bus.d_rdata),   64'h1234_5678);
    bus.if_req  = 1'b0;
    bus.mem_ack = 1'b0;
    tick();

    // Slow memory, requester withdraws mid-transaction
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_func3 = 3'b100;
    bus.d_addr  = 32'h80;
    bus.d_wdata = 32'h5555_0000;
    tick();
    chk("s.mem_we",    64'(bus.mem_we),    64'd0);
    chk("s.mem_func3", 64'(bus.mem_func3), 64'd4);
    bus.d_req   = 1'b0;
    bus.d_addr  = 32'hFFFF_FFFC;
    bus.d_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s.req",   64'(bus.mem_req),   64'd1);
      chk("s.addr",  64'(bus.mem_addr),  64'h80);
      chk("s.wdata", 64'(bus.mem_wdata), 64'h5555_0000);
      chk("s.noack", 64'(bus.d_ack),     64'd0);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    chk("s.d_ack",     64'(bus.d_ack),     64'd1);
    chk("s.d_rdata",   64'(bus.d_rdata),   64'hCAFE_F00D);
    bus.mem_rdata = 32'h0BAD_BEEF;
    tick();
    chk("s.one_ack",   64'(bus.d_ack),     64'd0);
    chk("s.resp_ign",  64'(bus.d_rdata),   64'hCAFE_F00D);
    chk("s.idle_req",  64'(bus.mem_req),   64'd0);
    bus.mem_ack = 1'b0;

    // Halt blocks new grants
    halt        = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h30;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("h.no_req",  64'(bus.mem_req),   64'd0);
    end
    halt = 1'b0;
    tick();
    chk("h.release",   64'(bus.mem_req),   64'd1);
    chk("h.rel_addr",  64'(bus.mem_addr),  64'h30);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h13;
    tick();
    chk("h.if_ack",    64'(bus.if_ack),    64'd1);
    bus.if_req  = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_func3 = 3'b010;
    bus.d_addr  = 32'h44;
    tick();
    chk("h.d_req",     64'(bus.mem_req),   64'd1);
    chk("h.d_addr",    64'(bus.mem_addr),  64'h44);
    halt = 1'b1;
    tick();
    chk("h.inflight",  64'(bus.mem_req),   64'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77;
    tick();
    chk("h.d_ack",     64'(bus.d_ack),     64'd1);
    chk("h.d_rdata",   64'(bus.d_rdata),   64'h77);
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("h.blocked", 64'(bus.mem_req),   64'd0);
      chk("h.busy0",   64'(busy),          64'd0);
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    halt       = 1'b0;
    tick();

    // Reset mid-transaction
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h60;
    bus.d_wdata = 32'h11;
    tick();
    chk("r.d_wait",    64'(bus.mem_req),   64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("r.async");
    bus.d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    tick();
    chk("r.f_req",     64'(bus.mem_req),   64'd1);
    chk("r.f_addr",    64'(bus.mem_addr),  64'h20);
    chk("r.no_dack",   64'(bus.d_ack),     64'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0010_0073;
    tick();
    chk("r.if_ack",    64'(bus.if_ack),    64'd1);
    chk("r.if_rdata",  64'(bus.if_rdata),  64'h0010_0073);
    chk("r.no_dack2",  64'(bus.d_ack),     64'd0);
    bus.if_req  = 1'b0;
    bus.mem_ack = 1'b0;
    tick();

    // Streak: both requesters held continuously
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_func3 = 3'b010;
    bus.d_addr  = 32'h200;
    tick();
    for (int g = 0; g < 8; g++) begin
      exp_fetch = guard_on && (g == 4);
      chk("g.req",     64'(bus.mem_req),   64'd1);
      chk("g.addr",    64'(bus.mem_addr),  exp_fetch ? 64'h100 : 64'h200);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'(g);
      tick();
      chk("g.if_ack",  64'(bus.if_ack),    64'(exp_fetch));
      chk("g.d_ack",   64'(bus.d_ack),     64'(!exp_fetch));
      bus.mem_ack = 1'b0;
      tick();
      chk("g.gap",     64'(bus.mem_req),   64'd0);
      tick();
    end
    bus.if_req  = 1'b0;
    bus.d_req   = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
